// File: rtl/ex_pipe_hazard_unit.sv
// rtl/ex_pipe_hazard_unit.sv - ID/EX and EX/MEM pipeline registers with stall/redirect hazard control
module ex_pipe_hazard_unit #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] id_pc,
  input  logic [25:0]       id_jump_addr,
  input  logic [3:0]        id_op,
  input  logic [DWIDTH-1:0] id_imm,
  input  logic [DWIDTH-1:0] id_rs1,
  input  logic [DWIDTH-1:0] id_rs2,
  input  logic [4:0]        id_rs1_id,
  input  logic [4:0]        id_rs2_id,
  input  logic [4:0]        id_rdst_id,
  input  logic              id_we_reg,
  input  logic              id_we_dmem,
  input  logic              id_ssel,
  input  logic [1:0]        id_wbsel,
  input  logic [2:0]        id_jump_type,
  input  logic [DWIDTH-1:0] alu_out,
  input  logic              alu_zero,
  output logic [DWIDTH-1:0] ex_pc,
  output logic [DWIDTH-1:0] ex_imm,
  output logic [DWIDTH-1:0] ex_rs1,
  output logic [DWIDTH-1:0] ex_rs2,
  output logic [DWIDTH-1:0] ex_ra,
  output logic [31:0]       ex_jump_addr,
  output logic [3:0]        ex_op,
  output logic [4:0]        ex_rdst_id,
  output logic [1:0]        ex_wbsel,
  output logic [2:0]        ex_jump_type,
  output logic              ex_we_reg,
  output logic              ex_we_dmem,
  output logic              ex_ssel,
  output logic [DWIDTH-1:0] mem_pc,
  output logic [DWIDTH-1:0] mem_rd,
  output logic [DWIDTH-1:0] mem_rs2,
  output logic [4:0]        mem_rdst_id,
  output logic [1:0]        mem_wbsel,
  output logic              mem_we_reg,
  output logic              mem_we_dmem,
  output logic              ex_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush
);

  localparam logic [2:0] JT_NOP = 3'b000;
  localparam logic [2:0] JT_BEQ = 3'b001;
  localparam logic [2:0] JT_JAL = 3'b010;
  localparam logic [2:0] JT_JR  = 3'b011;
  localparam logic [2:0] JT_J   = 3'b100;

  logic hz_ex;
  logic hz_mem;
  logic stall;

  // Resolve the control transfer of the instruction currently in EX; unknown codes never redirect.
  always_comb begin
    ex_taken = 1'b0;
    case (ex_jump_type)
      JT_NOP:  ex_taken = 1'b0;
      JT_BEQ:  ex_taken = alu_zero;
      JT_JAL:  ex_taken = 1'b1;
      JT_JR:   ex_taken = 1'b1;
      JT_J:    ex_taken = 1'b1;
      default: ex_taken = 1'b0;
    endcase
  end

  // RAW detection against EX and MEM writers; r0 is never a source of a hazard.
  always_comb begin
    hz_ex  = ex_we_reg && (ex_rdst_id != 5'd0) &&
             ((ex_rdst_id == id_rs1_id) || (ex_rdst_id == id_rs2_id));
    hz_mem = mem_we_reg && (mem_rdst_id != 5'd0) &&
             ((mem_rdst_id == id_rs1_id) || (mem_rdst_id == id_rs2_id));
    stall  = hz_ex || hz_mem;
  end

  // Front-end enables and squash controls; a taken redirect overrides a stall since ID is squashed anyway.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end else if (ex_taken) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // ID/EX register: reset and flush both produce an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || idex_flush) begin
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_ra        <= '0;
      ex_jump_addr <= '0;
      ex_op        <= '0;
      ex_rdst_id   <= '0;
      ex_wbsel     <= '0;
      ex_jump_type <= JT_NOP;
      ex_we_reg    <= 1'b0;
      ex_we_dmem   <= 1'b0;
      ex_ssel      <= 1'b0;
    end else begin
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_ra        <= id_pc + DWIDTH'(4);
      ex_jump_addr <= {6'd0, id_jump_addr};
      ex_op        <= id_op;
      ex_rdst_id   <= id_rdst_id;
      ex_wbsel     <= id_wbsel;
      ex_jump_type <= id_jump_type;
      ex_we_reg    <= id_we_reg;
      ex_we_dmem   <= id_we_dmem;
      ex_ssel      <= id_ssel;
    end
  end

  // EX/MEM register: loads unconditionally so an EX bubble arrives with zero write enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_pc      <= '0;
      mem_rd      <= '0;
      mem_rs2     <= '0;
      mem_rdst_id <= '0;
      mem_wbsel   <= '0;
      mem_we_reg  <= 1'b0;
      mem_we_dmem <= 1'b0;
    end else begin
      mem_pc      <= ex_pc;
      mem_rd      <= alu_out;
      mem_rs2     <= ex_rs2;
      mem_rdst_id <= ex_rdst_id;
      mem_wbsel   <= ex_wbsel;
      mem_we_reg  <= ex_we_reg;
      mem_we_dmem <= ex_we_dmem;
    end
  end

endmodule

// File: tb/tb_ex_pipe_hazard_unit.sv
// tb/tb_ex_pipe_hazard_unit.sv - randomized and directed checks of ex_pipe_hazard_unit against a pipeline model
module tb_ex_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc, id_imm, id_rs1, id_rs2, alu_out;
  logic [25:0] id_jump_addr;
  logic [3:0]  id_op;
  logic [4:0]  id_rs1_id, id_rs2_id, id_rdst_id;
  logic        id_we_reg, id_we_dmem, id_ssel, alu_zero;
  logic [1:0]  id_wbsel;
  logic [2:0]  id_jump_type;

  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_ra, ex_jump_addr;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rdst_id, mem_rdst_id;
  logic [1:0]  ex_wbsel, mem_wbsel;
  logic [2:0]  ex_jump_type;
  logic        ex_we_reg, ex_we_dmem, ex_ssel;
  logic [31:0] mem_pc, mem_rd, mem_rs2;
  logic        mem_we_reg, mem_we_dmem;
  logic        ex_taken, pc_write, ifid_write, ifid_flush, idex_flush;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_pipe_hazard_unit #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_jump_addr(id_jump_addr), .id_op(id_op), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
    .id_rdst_id(id_rdst_id), .id_we_reg(id_we_reg), .id_we_dmem(id_we_dmem),
    .id_ssel(id_ssel), .id_wbsel(id_wbsel), .id_jump_type(id_jump_type),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_ra(ex_ra),
    .ex_jump_addr(ex_jump_addr), .ex_op(ex_op), .ex_rdst_id(ex_rdst_id),
    .ex_wbsel(ex_wbsel), .ex_jump_type(ex_jump_type), .ex_we_reg(ex_we_reg),
    .ex_we_dmem(ex_we_dmem), .ex_ssel(ex_ssel),
    .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_rs2(mem_rs2), .mem_rdst_id(mem_rdst_id),
    .mem_wbsel(mem_wbsel), .mem_we_reg(mem_we_reg), .mem_we_dmem(mem_we_dmem),
    .ex_taken(ex_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush)
  );

  typedef struct {
    logic [31:0] pc, imm, rs1, rs2, ra, jaddr;
    logic [3:0]  op;
    logic [4:0]  rdst;
    logic [1:0]  wbsel;
    logic [2:0]  jt;
    logic        we_reg, we_dmem, ssel;
  } ex_stage_t;

  typedef struct {
    logic [31:0] pc, rd, rs2;
    logic [4:0]  rdst;
    logic [1:0]  wbsel;
    logic        we_reg, we_dmem;
  } mem_stage_t;

  ex_stage_t  m_ex;
  mem_stage_t m_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ex_stage_t bubble_ex();
    ex_stage_t b;
    b.pc = 0; b.imm = 0; b.rs1 = 0; b.rs2 = 0; b.ra = 0; b.jaddr = 0;
    b.op = 0; b.rdst = 0; b.wbsel = 0; b.jt = 0;
    b.we_reg = 0; b.we_dmem = 0; b.ssel = 0;
    return b;
  endfunction

  function automatic mem_stage_t bubble_mem();
    mem_stage_t b;
    b.pc = 0; b.rd = 0; b.rs2 = 0; b.rdst = 0; b.wbsel = 0; b.we_reg = 0; b.we_dmem = 0;
    return b;
  endfunction

  // A writer in a later stage blocks ID if it targets a nonzero register that ID reads.
  function automatic bit conflicts(input bit we, input int rdst, input int a, input int b);
    return we && rdst != 0 && (rdst == a || rdst == b);
  endfunction

  function automatic bit model_taken();
    if (m_ex.jt == 3'd1) return alu_zero;
    return (m_ex.jt == 3'd2) || (m_ex.jt == 3'd3) || (m_ex.jt == 3'd4);
  endfunction

  // Checks the combinational outputs, clocks once, advances the model and checks the registers.
  task automatic step();
    bit tk, st, e_pcw, e_ifw, e_iff, e_idf;
    ex_stage_t  nx;
    mem_stage_t nm;
    #1;
    tk = model_taken();
    st = conflicts(m_ex.we_reg, m_ex.rdst, id_rs1_id, id_rs2_id) ||
         conflicts(m_mem.we_reg, m_mem.rdst, id_rs1_id, id_rs2_id);
    if (rst)     begin e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; end
    else if (tk) begin e_pcw = 1; e_ifw = 1; e_iff = 1; e_idf = 1; end
    else if (st) begin e_pcw = 0; e_ifw = 0; e_iff = 0; e_idf = 1; end
    else         begin e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; end
    chk("ex_taken", 32'(ex_taken), 32'(tk));
    chk("pc_write", 32'(pc_write), 32'(e_pcw));
    chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_iff));
    chk("idex_flush", 32'(idex_flush), 32'(e_idf));

    nm.pc = m_ex.pc; nm.rd = alu_out; nm.rs2 = m_ex.rs2; nm.rdst = m_ex.rdst;
    nm.wbsel = m_ex.wbsel; nm.we_reg = m_ex.we_reg; nm.we_dmem = m_ex.we_dmem;
    nx.pc = id_pc; nx.imm = id_imm; nx.rs1 = id_rs1; nx.rs2 = id_rs2;
    nx.ra = id_pc + 32'd4; nx.jaddr = 32'(id_jump_addr); nx.op = id_op;
    nx.rdst = id_rdst_id; nx.wbsel = id_wbsel; nx.jt = id_jump_type;
    nx.we_reg = id_we_reg; nx.we_dmem = id_we_dmem; nx.ssel = id_ssel;
    if (rst || e_idf) nx = bubble_ex();
    if (rst) nm = bubble_mem();

    @(posedge clk);
    m_ex = nx;
    m_mem = nm;
    #1;
    chk("ex_pc", ex_pc, m_ex.pc);
    chk("ex_imm", ex_imm, m_ex.imm);
    chk("ex_rs1", ex_rs1, m_ex.rs1);
    chk("ex_rs2", ex_rs2, m_ex.rs2);
    chk("ex_ra", ex_ra, m_ex.ra);
    chk("ex_jump_addr", ex_jump_addr, m_ex.jaddr);
    chk("ex_ctl", {13'd0, ex_op, ex_rdst_id, ex_wbsel, ex_jump_type, ex_we_reg, ex_we_dmem, ex_ssel},
        {13'd0, m_ex.op, m_ex.rdst, m_ex.wbsel, m_ex.jt, m_ex.we_reg, m_ex.we_dmem, m_ex.ssel});
    chk("mem_pc", mem_pc, m_mem.pc);
    chk("mem_rd", mem_rd, m_mem.rd);
    chk("mem_rs2", mem_rs2, m_mem.rs2);
    chk("mem_ctl", {22'd0, mem_rdst_id, mem_wbsel, mem_we_reg, mem_we_dmem},
        {22'd0, m_mem.rdst, m_mem.wbsel, m_mem.we_reg, m_mem.we_dmem});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; id_pc = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0; alu_out = 0;
    id_jump_addr = 0; id_op = 0; id_rs1_id = 0; id_rs2_id = 0; id_rdst_id = 0;
    id_we_reg = 0; id_we_dmem = 0; id_ssel = 0; alu_zero = 0; id_wbsel = 0; id_jump_type = 0;
  endtask

  task automatic random_inputs();
    rst = ($urandom_range(0, 39) == 0);
    id_pc = $urandom; id_imm = $urandom; id_rs1 = $urandom; id_rs2 = $urandom;
    alu_out = $urandom; id_jump_addr = 26'($urandom); id_op = 4'($urandom);
    id_rs1_id = 5'($urandom_range(0, 6)); id_rs2_id = 5'($urandom_range(0, 6));
    id_rdst_id = 5'($urandom_range(0, 6));
    id_we_reg = 1'($urandom); id_we_dmem = 1'($urandom); id_ssel = 1'($urandom);
    alu_zero = 1'($urandom); id_wbsel = 2'($urandom);
    id_jump_type = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
  endtask

  initial begin
    m_ex = bubble_ex();
    m_mem = bubble_mem();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset with busy inputs
    random_inputs();
    rst = 1;
    #1;
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_flushes", {30'd0, ifid_flush, idex_flush}, 32'd0);
    step();
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_mem_we", {30'd0, mem_we_reg, mem_we_dmem}, 32'd0);

    // Pass-through into EX then MEM
    idle_inputs();
    id_pc = 32'h100; id_imm = 32'hFFFF_FFFC; id_rdst_id = 5'd5; id_we_reg = 1;
    step();
    chk("pt_ex_pc", ex_pc, 32'h100);
    chk("pt_ex_ra", ex_ra, 32'h104);
    chk("pt_ex_imm", ex_imm, 32'hFFFF_FFFC);
    idle_inputs();
    alu_out = 32'h55;
    step();
    chk("pt_mem_rd", mem_rd, 32'h55);
    chk("pt_mem_rdst", 32'(mem_rdst_id), 32'd5);
    chk("pt_mem_we", 32'(mem_we_reg), 32'd1);

    // EX RAW stall persisting through MEM, then release
    idle_inputs();
    id_rdst_id = 5'd5; id_we_reg = 1;
    step();
    idle_inputs();
    id_rs2_id = 5'd5;
    #1;
    chk("raw_ex_pcw", {29'd0, pc_write, ifid_write, idex_flush}, 32'b001);
    step();
    #1;
    chk("raw_mem_pcw", {29'd0, pc_write, ifid_write, idex_flush}, 32'b001);
    step();
    #1;
    chk("raw_release", {29'd0, pc_write, ifid_write, idex_flush}, 32'b110);
    step();

    // r0 writer never stalls
    idle_inputs();
    id_rdst_id = 5'd0; id_we_reg = 1;
    step();
    idle_inputs();
    #1;
    chk("r0_no_stall", {30'd0, pc_write, idex_flush}, 32'b10);
    step();

    // BEQ taken and not taken
    for (int z = 1; z >= 0; z--) begin
      idle_inputs();
      id_jump_type = 3'd1;
      step();
      idle_inputs();
      alu_zero = 1'(z);
      #1;
      chk("beq_taken", 32'(ex_taken), 32'(z));
      chk("beq_flush", {30'd0, ifid_flush, idex_flush}, z ? 32'b11 : 32'b00);
      step();
    end

    // JR with a concurrent MEM RAW hazard
    idle_inputs();
    id_rdst_id = 5'd7; id_we_reg = 1;
    step();
    idle_inputs();
    id_jump_type = 3'd3;
    step();
    idle_inputs();
    id_rs1_id = 5'd7;
    #1;
    chk("jr_over_stall", {28'd0, ex_taken, pc_write, ifid_flush, idex_flush}, 32'b1111);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      random_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_pipe_hazard_unit.md
Name: ex_pipe_hazard_unit

Overview:
Holds the ID/EX and EX/MEM pipeline registers of the 5-stage 32-bit MIPS-like core, plus the combinational hazard/redirect controller that drives them. There is no forwarding: read-after-write hazards against the EX and MEM stages are resolved by stalling. Taken control transfers resolved in EX squash the younger IF/ID and ID/EX contents.

Parameters:
DWIDTH, 32, datapath width (pc, operands, immediate, ALU result)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_pc  in  DWIDTH  pc of the instruction in ID
id_jump_addr  in  26  J/JAL target field
id_op  in  4  ALU opcode
id_imm  in  DWIDTH  sign-extended immediate
id_rs1, id_rs2  in  DWIDTH  register-file read data
id_rs1_id, id_rs2_id  in  5  source register ids of the ID instruction
id_rdst_id  in  5  destination register id
id_we_reg, id_we_dmem, id_ssel  in  1  control bits
id_wbsel  in  2  writeback select (00 ALU, 01 dmem, 10 pc+4)
id_jump_type  in  3  000 NOP, 001 BEQ, 010 JAL, 011 JR, 100 J
alu_out  in  DWIDTH  EX-stage ALU result
alu_zero  in  1  EX-stage ALU zero flag
ex_pc, ex_imm, ex_rs1, ex_rs2, ex_ra  out  DWIDTH  registered ID/EX fields (ex_ra = id_pc+4)
ex_jump_addr  out  32  id_jump_addr zero-extended
ex_op  out  4;  ex_rdst_id  out  5;  ex_wbsel  out  2;  ex_jump_type  out  3
ex_we_reg, ex_we_dmem, ex_ssel  out  1
mem_pc, mem_rd, mem_rs2  out  DWIDTH  registered EX/MEM fields (mem_rd = alu_out)
mem_rdst_id  out  5;  mem_wbsel  out  2;  mem_we_reg, mem_we_dmem  out  1
ex_taken  out  1  EX-stage control transfer taken
pc_write, ifid_write  out  1  PC and IF/ID load enables
ifid_flush, idex_flush  out  1  squash controls

Behaviour:
- ID/EX register: every clock edge. Priority rst > idex_flush > load. Both rst and flush clear every field to 0; the result is a bubble (jump_type NOP, we_reg=0, we_dmem=0).
- EX/MEM register: every clock edge. Priority rst > load. It loads ex_pc, alu_out, ex_rs2, ex_rdst_id, ex_wbsel, ex_we_reg and ex_we_dmem. A bubble in EX propagates as all-zero write enables.
- All registered outputs are 0 after reset.
- ex_taken (combinational from EX fields):
  - true when ex_jump_type is BEQ and alu_zero=1;
  - true when ex_jump_type is JAL, J or JR;
  - false otherwise, including unknown codes 101–111.
- Hazard detection (combinational):
  - hz_ex = ex_we_reg & ex_rdst_id!=0 & (ex_rdst_id==id_rs1_id | ex_rdst_id==id_rs2_id).
  - hz_mem is the same test using mem_we_reg and mem_rdst_id.
  - stall = hz_ex | hz_mem. Both source ids are checked regardless of instruction type, which is conservative.
  - The WB-stage hazard is handled by the register file (write-before-read) and is out of scope here.
- Control outputs:
  - ex_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. Redirect beats stall because the stalled ID instruction is squashed.
  - else stall=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1. This inserts a bubble and holds the instruction in ID.
  - else: pc_write=1, ifid_write=1, both flushes 0.
- During rst=1: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
- Latency: one cycle per register. Hazard outputs are purely combinational from current register state and ID inputs.
- Register 0 is never a hazard source.

Test Plan:
- Reset: assert rst one cycle with nonzero inputs -> all ex_*/mem_* = 0, pc_write=1, ifid_write=1, flushes 0.
- Pass-through: id_pc=0x100, id_imm=0xFFFF_FFFC, id_rdst_id=5, id_we_reg=1, no hazard -> next cycle ex_pc=0x100, ex_ra=0x104, ex_imm=0xFFFF_FFFC. The following cycle with alu_out=0x55 -> mem_rd=0x55, mem_rdst_id=5, mem_we_reg=1.
- EX RAW stall: EX holds rdst 5 with we_reg=1, id_rs2_id=5 -> pc_write=0, ifid_write=0, idex_flush=1. Next cycle EX is a bubble (all 0) and MEM holds rdst 5, so the stall persists one more cycle, then it releases.
- Reg-0 exemption: EX rdst=0, we_reg=1, id_rs1_id=0 -> no stall.
- BEQ: ex_jump_type=001. With alu_zero=1 -> ex_taken=1, ifid_flush=1, idex_flush=1, pc_write=1. With alu_zero=0 -> ex_taken=0, no flush.
- Simultaneous: ex_jump_type=JR with a concurrent MEM RAW hazard -> redirect wins: pc_write=1, ifid_flush=1, idex_flush=1.
